// File: rtl/sgpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sgpio_pkg
//  Purpose  : Shared types and helpers for the oversampled SGPIO slave.
//             - state_t   : link state machine encoding
//             - ERR_CNT_W : width of the saturating error counter
//             - cnt_width : bits needed to hold a counter value 0..max_val
//  Revision : 1.0 - initial release
// ============================================================================
package sgpio_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 8;

  // Width of a counter that must represent every value from 0 to max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sgpio_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module   : sgpio_pin_sync
//  Purpose  : Multi-stage synchronisers for the three SGPIO input pins plus a
//             rising-edge detector on the synchronised serial clock.
//  Ports    : clk, rst            - system clock, synchronous active-high reset
//             sgpio_clk/sync/mosi - asynchronous pin inputs
//             rise                - one-cycle strobe on a serial clock rise
//             sync_s, mosi_s      - synchronised sync / data, valid with rise
//  Revision : 1.0 - initial release
// ============================================================================
module sgpio_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sgpio_clk,
  input  logic sgpio_sync,
  input  logic sgpio_mosi,
  output logic rise,
  output logic sync_s,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] sync_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   clk_prev;

  // All three pins share the same depth so data and sync line up with the
  // clock edge they were launched against.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sr   <= '0;
      sync_sr  <= '0;
      mosi_sr  <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sr   <= {clk_sr[SYNC_STAGES-2:0],  sgpio_clk};
      sync_sr  <= {sync_sr[SYNC_STAGES-2:0], sgpio_sync};
      mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], sgpio_mosi};
      clk_prev <= clk_sr[SYNC_STAGES-1];
    end
  end

  assign rise   = clk_sr[SYNC_STAGES-1] & ~clk_prev;
  assign sync_s = sync_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/sgpio_slave_os.sv
`default_nettype none
// ============================================================================
//  Module   : sgpio_slave_os
//  Purpose  : Oversampled SGPIO slave in the system clock domain. Exchanges
//             W-bit LSB-first frames, checks frame length, qualifies lock
//             after LOCK_FRAMES good frames, detects link loss and counts
//             errors.
//  Ports    : i_clk, i_rst          - system clock, sync active-high reset
//             i_sgpio_clk/sync/mosi - asynchronous SGPIO pins
//             o_sgpio_miso          - slave data out (idles high)
//             i_tx_data             - LED word, captured at each sync edge
//             o_rx_data             - last good received frame
//             o_rx_valid            - high while locked
//             o_rx_update           - pulse when o_rx_data loads
//             o_frame_err           - pulse on a bad-length frame
//             o_err_cnt             - saturating frame error + timeout count
//  Revision : 1.0 - initial release
// ============================================================================
module sgpio_slave_os
  import sgpio_pkg::*;
#(
  parameter int         W           = 8,
  parameter int         LOCK_FRAMES = 2,
  parameter int         TIMEOUT_CYC = 1024,
  parameter int         SYNC_STAGES = 2,
  parameter logic [W-1:0] RX_RESET  = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sgpio_clk,
  input  logic                 i_sgpio_sync,
  input  logic                 i_sgpio_mosi,
  output logic                 o_sgpio_miso,
  input  logic [W-1:0]         i_tx_data,
  output logic [W-1:0]         o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_rx_update,
  output logic                 o_frame_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam int BC_W = cnt_width(W + 1);
  localparam int TM_W = cnt_width(TIMEOUT_CYC);
  localparam int GC_W = cnt_width(LOCK_FRAMES);

  logic rise;
  logic sync_s;
  logic mosi_s;

  sgpio_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk        (i_clk),
    .rst        (i_rst),
    .sgpio_clk  (i_sgpio_clk),
    .sgpio_sync (i_sgpio_sync),
    .sgpio_mosi (i_sgpio_mosi),
    .rise       (rise),
    .sync_s     (sync_s),
    .mosi_s     (mosi_s)
  );

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   shift_in;
  logic [W-1:0]   tx_shift;
  logic [BC_W-1:0] bit_cnt;
  logic [GC_W-1:0] good_cnt;
  logic [GC_W-1:0] good_nxt;
  logic [TM_W-1:0] timer;
  logic           valid_nxt;
  logic           latch;
  logic           bad;
  logic           tout;

  logic sync_rise;
  logic frame_good;
  logic timeout_hit;

  assign sync_rise  = rise & sync_s;
  // bit_cnt counts the sync bit as 1, so a complete frame reads exactly W.
  assign frame_good = (bit_cnt == BC_W'(W));
  // Fires once, on the cycle the idle timer steps onto TIMEOUT_CYC.
  assign timeout_hit = !rise && (timer == TM_W'(TIMEOUT_CYC - 1)) &&
                       (state != HUNT);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and framing decisions
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    valid_nxt = o_rx_valid;
    latch     = 1'b0;
    bad       = 1'b0;
    tout      = 1'b0;
    if (sync_rise) begin
      case (state)
        HUNT: begin
          // No earlier sync to measure against, so nothing can be judged.
          state_nxt = ALIGN;
          good_nxt  = '0;
        end
        default: begin
          if (frame_good) begin
            latch = 1'b1;
            if (good_cnt >= GC_W'(LOCK_FRAMES - 1)) begin
              good_nxt  = GC_W'(LOCK_FRAMES);
              state_nxt = LOCKED;
              valid_nxt = 1'b1;
            end else begin
              good_nxt = good_cnt + GC_W'(1);
            end
          end else begin
            bad       = 1'b1;
            state_nxt = ALIGN;
            good_nxt  = '0;
            valid_nxt = 1'b0;
          end
        end
      endcase
    end else if (timeout_hit) begin
      tout      = 1'b1;
      state_nxt = HUNT;
      valid_nxt = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: shifters, counters, outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_in     <= '0;
      tx_shift     <= '1;
      bit_cnt      <= '0;
      good_cnt     <= '0;
      timer        <= '0;
      o_sgpio_miso <= 1'b1;
      o_rx_data    <= RX_RESET;
      o_rx_valid   <= 1'b0;
      o_rx_update  <= 1'b0;
      o_frame_err  <= 1'b0;
      o_err_cnt    <= '0;
    end else begin
      o_rx_update  <= latch;
      o_frame_err  <= bad;
      o_rx_valid   <= valid_nxt;
      good_cnt     <= good_nxt;
      o_sgpio_miso <= tx_shift[0];

      if (rise) begin
        shift_in <= {mosi_s, shift_in[W-1:1]};
        timer    <= '0;
        if (sync_s) begin
          bit_cnt  <= BC_W'(1);
          tx_shift <= i_tx_data;
        end else begin
          if (bit_cnt != BC_W'(W + 1)) begin
            bit_cnt <= bit_cnt + BC_W'(1);
          end
          // Shift in 1s so the line idles high once the word is out.
          tx_shift <= {1'b1, tx_shift[W-1:1]};
        end
      end else begin
        if (timer != TM_W'(TIMEOUT_CYC)) begin
          timer <= timer + TM_W'(1);
        end
        if (tout) begin
          tx_shift <= '1;
        end
      end

      // shift_in still holds the completed frame: the sync bit belongs to
      // the next one.
      if (latch) begin
        o_rx_data <= shift_in;
      end

      if ((bad || tout) && (o_err_cnt != '1)) begin
        o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
